// File: rtl/uart_tx_arbiter.sv
// Purpose: round-robin scheduler sharing one UART Transmitter among NUM_REQ byte sources;
//          latches the winner's byte and times the whole serial frame, because the Transmitter has no busy/done.
// Ports:   i_clk/i_rst (sync, active-high); i_req/i_req_data from producers; o_ack one-cycle accept pulse;
//          o_tx_start/o_tx_data to the Transmitter; o_busy while a frame runs; o_grant_idx last served requester.
// Latency: req in IDLE -> ack/tx_start at next edge; back-to-back grants T+1 cycles apart (T = frame + guard).
// Backpressure: requests seen during START/FRAME are neither acked nor queued; requesters simply hold req.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = 10416,
  parameter int FRAME_BITS   = 10,
  parameter int GUARD_CLKS   = 0,
  localparam int IW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [8*NUM_REQ-1:0] i_req_data,
  output logic [NUM_REQ-1:0]   o_ack,
  output logic                 o_tx_start,
  output logic [7:0]           o_tx_data,
  output logic                 o_busy,
  output logic [IW-1:0]        o_grant_idx
);

  localparam int T_CLKS = FRAME_BITS * CLKS_PER_BIT + GUARD_CLKS;
  localparam int TW     = $clog2(T_CLKS + 1);

  localparam logic [TW-1:0] CPB_W   = TW'(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_W     = TW'(T_CLKS);
  localparam logic [IW:0]   NREQ_W  = (IW+1)'(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_FRAME = 2'd2
  } state_t;

  state_t               r_state;
  logic [NUM_REQ-1:0]   r_ack;
  logic                 r_tx_start;
  logic [7:0]           r_tx_data;
  logic                 r_busy;
  logic [IW-1:0]        r_grant_idx;
  logic [IW-1:0]        r_rr_ptr;
  logic [TW-1:0]        r_timer;

  state_t               w_state_nxt;
  logic [NUM_REQ-1:0]   w_ack_nxt;
  logic                 w_tx_start_nxt;
  logic [7:0]           w_tx_data_nxt;
  logic                 w_busy_nxt;
  logic [IW-1:0]        w_grant_idx_nxt;
  logic [IW-1:0]        w_rr_ptr_nxt;
  logic [TW-1:0]        w_timer_nxt;

  logic                 w_found;
  logic [IW-1:0]        w_win;
  logic [NUM_REQ-1:0]   w_win_oh;
  logic [7:0]           w_win_byte;
  logic [IW:0]          w_cand;
  logic [IW:0]          w_rr_inc;

  // Round-robin search: walk rr_ptr, rr_ptr+1, ... (mod NUM_REQ) and take the first pending request.
  // The candidate sum never exceeds 2*NUM_REQ-2, so one conditional subtract implements the wrap.
  always_comb begin
    w_found    = 1'b0;
    w_win      = '0;
    w_win_oh   = '0;
    w_cand     = '0;
    w_win_byte = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_cand = {1'b0, r_rr_ptr} + (IW+1)'(i);
      if (w_cand >= NREQ_W) begin
        w_cand = w_cand - NREQ_W;
      end
      if (!w_found && i_req[w_cand[IW-1:0]]) begin
        w_found                    = 1'b1;
        w_win                      = w_cand[IW-1:0];
        w_win_oh[w_cand[IW-1:0]]   = 1'b1;
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (w_win_oh[j]) begin
        w_win_byte = i_req_data[8*j +: 8];
      end
    end
  end

  // Pointer moves just past the requester that was served, wrapping NUM_REQ-1 -> 0.
  always_comb begin
    w_rr_inc = {1'b0, r_grant_idx} + (IW+1)'(1);
    if (w_rr_inc == NREQ_W) begin
      w_rr_inc = '0;
    end
  end

  // Next-state and registered-output values. The timer counts cycles since the grant edge
  // (value 1 right after it), so START ends at CLKS_PER_BIT and the frame ends at T.
  always_comb begin
    w_state_nxt     = r_state;
    w_ack_nxt       = '0;
    w_tx_start_nxt  = r_tx_start;
    w_tx_data_nxt   = r_tx_data;
    w_busy_nxt      = r_busy;
    w_grant_idx_nxt = r_grant_idx;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_timer_nxt     = r_timer;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_ack_nxt       = w_win_oh;
          w_tx_data_nxt   = w_win_byte;
          w_grant_idx_nxt = w_win;
          w_tx_start_nxt  = 1'b1;
          w_busy_nxt      = 1'b1;
          w_timer_nxt     = TW'(1);
          w_state_nxt     = S_START;
        end
      end
      S_START: begin
        w_timer_nxt = r_timer + TW'(1);
        // Start is held a full bit time so the Transmitter's baud sampler cannot miss it.
        if (r_timer == CPB_W) begin
          w_tx_start_nxt = 1'b0;
          w_state_nxt    = S_FRAME;
        end
      end
      S_FRAME: begin
        w_timer_nxt = r_timer + TW'(1);
        if (r_timer == T_W) begin
          w_busy_nxt   = 1'b0;
          w_rr_ptr_nxt = w_rr_inc[IW-1:0];
          w_timer_nxt  = '0;
          w_state_nxt  = S_IDLE;
        end
      end
      default: begin
        w_tx_start_nxt = 1'b0;
        w_busy_nxt     = 1'b0;
        w_timer_nxt    = '0;
        w_state_nxt    = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_ack       <= '0;
      r_tx_start  <= 1'b0;
      r_tx_data   <= 8'h00;
      r_busy      <= 1'b0;
      r_grant_idx <= '0;
      r_rr_ptr    <= '0;
      r_timer     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ack       <= w_ack_nxt;
      r_tx_start  <= w_tx_start_nxt;
      r_tx_data   <= w_tx_data_nxt;
      r_busy      <= w_busy_nxt;
      r_grant_idx <= w_grant_idx_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_timer     <= w_timer_nxt;
    end
  end

  assign o_ack       = r_ack;
  assign o_tx_start  = r_tx_start;
  assign o_tx_data   = r_tx_data;
  assign o_busy      = r_busy;
  assign o_grant_idx = r_grant_idx;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter with CLKS_PER_BIT=4, FRAME_BITS=10, GUARD_CLKS=2 (T=42), NUM_REQ=4.
// Expected grants (index, byte) are queued when requests are driven and popped when ack appears.
module tb_uart_tx_arbiter;

  localparam int NR  = 4;
  localparam int CPB = 4;
  localparam int FB  = 10;
  localparam int GC  = 2;
  localparam int T   = FB * CPB + GC;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] req = '0;
  logic [8*NR-1:0] req_data = '0;
  logic [NR-1:0] ack;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          busy;
  logic [1:0]    grant_idx;

  uart_tx_arbiter #(
    .NUM_REQ(NR), .CLKS_PER_BIT(CPB), .FRAME_BITS(FB), .GUARD_CLKS(GC)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_req_data(req_data),
    .o_ack(ack), .o_tx_start(tx_start), .o_tx_data(tx_data),
    .o_busy(busy), .o_grant_idx(grant_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct { int idx; logic [7:0] dat; } exp_t;
  exp_t sb[$];

  // More than one ack bit at once is never legal.
  always @(negedge clk) begin
    if (ack !== 4'b0000) begin
      n_tests++;
      if (!$onehot(ack)) begin
        n_fail++;
        $display("FAIL ack_onehot: got ack=%b, required a single bit", ack);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input int idx, input logic [7:0] dat);
    exp_t e;
    e.idx = idx;
    e.dat = dat;
    sb.push_back(e);
  endtask

  task automatic set_byte(input int i, input logic [7:0] b);
    req_data[8*i +: 8] = b;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Steps negedges until ack appears; reports how many negedges that took.
  task automatic wait_ack(input int budget, output bit got, output int waited);
    got = 1'b0;
    waited = 0;
    while (!got && waited < budget) begin
      @(negedge clk);
      waited++;
      if (ack !== 4'b0000) got = 1'b1;
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 200) begin
      @(negedge clk);
      k++;
    end
  endtask

  // Counts from the current (ack) negedge until busy drops.
  task automatic measure_frame(output int n_start, output int n_busy, output int n_ack);
    int k;
    n_start = 0; n_busy = 0; n_ack = 0; k = 0;
    while (busy === 1'b1 && k < 200) begin
      n_start += int'(tx_start);
      n_busy++;
      if (ack !== 4'b0000) n_ack++;
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_tests++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack: got %b, required 0000", ack); end
    n_tests++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start: got %b, required 0", tx_start); end
    n_tests++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h, required 00", tx_data); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
    n_tests++; if (grant_idx !== 2'd0) begin n_fail++; $display("FAIL reset_grant_idx: got %0d, required 0", grant_idx); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    bit got; int w, ns, nb, na; exp_t e;
    set_byte(1, 8'hA5);
    req = 4'b0010;
    push_exp(1, 8'hA5);
    wait_ack(10, got, w);
    req = 4'b0000;
    e = sb.pop_front();
    n_tests++;
    if (!got || ack !== 4'(1 << e.idx) || tx_data !== e.dat || grant_idx !== 2'(e.idx)) begin
      n_fail++;
      $display("FAIL single_grant: got ack=%b data=%h idx=%0d, required ack=%b data=%h idx=%0d",
               ack, tx_data, grant_idx, 4'(1 << e.idx), e.dat, e.idx);
    end
    n_tests++; if (w !== 1) begin n_fail++; $display("FAIL single_latency: got %0d cycles, required 1", w); end
    measure_frame(ns, nb, na);
    n_tests++; if (ns !== CPB) begin n_fail++; $display("FAIL single_tx_start_len: got %0d, required %0d", ns, CPB); end
    n_tests++; if (nb !== T) begin n_fail++; $display("FAIL single_busy_len: got %0d, required %0d", nb, T); end
    n_tests++; if (na !== 1) begin n_fail++; $display("FAIL single_ack_len: got %0d, required 1", na); end
  endtask

  task automatic test_back_to_back();
    bit got; int w, t_prev; exp_t e;
    apply_reset();
    for (int i = 0; i < NR; i++) set_byte(i, 8'h10 + 8'(i));
    req = 4'b1111;
    for (int i = 0; i < 5; i++) push_exp(i % NR, 8'h10 + 8'(i % NR));
    t_prev = 0;
    for (int i = 0; i < 5; i++) begin
      wait_ack(60, got, w);
      if (i == 4) req = 4'b0000;
      e = sb.pop_front();
      n_tests++;
      if (!got || ack !== 4'(1 << e.idx) || tx_data !== e.dat || grant_idx !== 2'(e.idx)) begin
        n_fail++;
        $display("FAIL b2b_grant%0d: got ack=%b data=%h idx=%0d, required ack=%b data=%h idx=%0d",
                 i, ack, tx_data, grant_idx, 4'(1 << e.idx), e.dat, e.idx);
      end
      if (i > 0) begin
        n_tests++;
        if (cyc - t_prev !== T + 1) begin
          n_fail++;
          $display("FAIL b2b_spacing%0d: got %0d cycles, required %0d", i, cyc - t_prev, T + 1);
        end
      end
      t_prev = cyc;
    end
    wait_idle();
  endtask

  task automatic test_wrap();
    bit got; int w, t_prev; exp_t e;
    apply_reset();
    set_byte(3, 8'h33);
    req = 4'b1000;
    push_exp(3, 8'h33);
    push_exp(0, 8'h40);
    push_exp(3, 8'h43);
    t_prev = 0;
    for (int i = 0; i < 3; i++) begin
      wait_ack(60, got, w);
      case (i)
        0: req = 4'b0000;
        1: req = 4'b1000;
        default: req = 4'b0000;
      endcase
      e = sb.pop_front();
      n_tests++;
      if (!got || ack !== 4'(1 << e.idx) || tx_data !== e.dat || grant_idx !== 2'(e.idx)) begin
        n_fail++;
        $display("FAIL wrap_grant%0d: got ack=%b data=%h idx=%0d, required ack=%b data=%h idx=%0d",
                 i, ack, tx_data, grant_idx, 4'(1 << e.idx), e.dat, e.idx);
      end
      if (i > 0) begin
        n_tests++;
        if (cyc - t_prev !== T + 1) begin
          n_fail++;
          $display("FAIL wrap_spacing%0d: got %0d cycles, required %0d", i, cyc - t_prev, T + 1);
        end
      end
      t_prev = cyc;
      if (i == 0) begin
        repeat (5) @(negedge clk);
        set_byte(0, 8'h40);
        set_byte(3, 8'h43);
        req = 4'b1001;
      end
    end
    wait_idle();
  endtask

  task automatic test_pulse_during_frame();
    bit got; int w, k, nb, na, post_ack, post_busy; exp_t e;
    set_byte(0, 8'h77);
    req = 4'b0001;
    push_exp(0, 8'h77);
    wait_ack(10, got, w);
    req = 4'b0000;
    e = sb.pop_front();
    n_tests++;
    if (!got || ack !== 4'(1 << e.idx) || tx_data !== e.dat) begin
      n_fail++;
      $display("FAIL pulse_grant: got ack=%b data=%h, required ack=%b data=%h", ack, tx_data, 4'(1 << e.idx), e.dat);
    end
    nb = 0; na = 0; k = 0;
    while (busy === 1'b1 && k < 200) begin
      nb++;
      if (ack !== 4'b0000) na++;
      if (k == 10) req = 4'b0100;
      if (k == 15) req = 4'b0000;
      @(negedge clk);
      k++;
    end
    post_ack = 0; post_busy = 0;
    repeat (50) begin
      if (ack !== 4'b0000) post_ack++;
      if (busy !== 1'b0) post_busy++;
      @(negedge clk);
    end
    n_tests++; if (nb !== T) begin n_fail++; $display("FAIL pulse_busy_len: got %0d, required %0d", nb, T); end
    n_tests++; if (na !== 1) begin n_fail++; $display("FAIL pulse_frame_acks: got %0d, required 1", na); end
    n_tests++; if (post_ack !== 0) begin n_fail++; $display("FAIL pulse_late_ack: got %0d acks, required 0", post_ack); end
    n_tests++; if (post_busy !== 0) begin n_fail++; $display("FAIL pulse_stays_idle: got %0d busy cycles, required 0", post_busy); end
  endtask

  task automatic test_reset_mid_frame();
    bit got; int w, ns, nb, na; exp_t e;
    set_byte(2, 8'h22);
    req = 4'b0100;
    push_exp(2, 8'h22);
    wait_ack(10, got, w);
    req = 4'b0000;
    e = sb.pop_front();
    n_tests++;
    if (!got || ack !== 4'(1 << e.idx) || tx_data !== e.dat) begin
      n_fail++;
      $display("FAIL rstmid_first_grant: got ack=%b data=%h, required ack=%b data=%h", ack, tx_data, 4'(1 << e.idx), e.dat);
    end
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_tests++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL rstmid_tx_start: got %b, required 0", tx_start); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b, required 0", busy); end
    n_tests++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL rstmid_ack: got %b, required 0000", ack); end
    rst = 1'b0;
    for (int i = 0; i < NR; i++) set_byte(i, 8'h50 + 8'(i));
    req = 4'b1111;
    push_exp(0, 8'h50);
    wait_ack(10, got, w);
    req = 4'b0000;
    e = sb.pop_front();
    n_tests++;
    if (!got || ack !== 4'(1 << e.idx) || tx_data !== e.dat || grant_idx !== 2'(e.idx)) begin
      n_fail++;
      $display("FAIL rstmid_regrant: got ack=%b data=%h idx=%0d, required ack=%b data=%h idx=%0d",
               ack, tx_data, grant_idx, 4'(1 << e.idx), e.dat, e.idx);
    end
    measure_frame(ns, nb, na);
    n_tests++; if (ns !== CPB) begin n_fail++; $display("FAIL rstmid_tx_start_len: got %0d, required %0d", ns, CPB); end
    n_tests++; if (nb !== T) begin n_fail++; $display("FAIL rstmid_busy_len: got %0d, required %0d", nb, T); end
  endtask

  task automatic test_data_hold();
    bit got; int w, k, bad; exp_t e;
    set_byte(1, 8'hA5);
    req = 4'b0010;
    push_exp(1, 8'hA5);
    wait_ack(10, got, w);
    req = 4'b0000;
    set_byte(1, 8'h5A);
    e = sb.pop_front();
    n_tests++;
    if (!got || ack !== 4'(1 << e.idx) || tx_data !== e.dat) begin
      n_fail++;
      $display("FAIL hold_grant: got ack=%b data=%h, required ack=%b data=%h", ack, tx_data, 4'(1 << e.idx), e.dat);
    end
    bad = 0; k = 0;
    while (busy === 1'b1 && k < 200) begin
      if (tx_data !== 8'hA5) bad++;
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL hold_frame_data: got %0d changed cycles, required 0", bad); end
    n_tests++; if (tx_data !== 8'hA5) begin n_fail++; $display("FAIL hold_idle_data: got %h, required a5", tx_data); end
    n_tests++; if (k !== T) begin n_fail++; $display("FAIL hold_busy_len: got %0d, required %0d", k, T); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap();
    test_pulse_during_frame();
    test_reset_mid_frame();
    test_data_hold();
    n_tests++;
    if (sb.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending grants, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
